// File: rtl/serial_pattern_tx_if.sv
// rtl/serial_pattern_tx_if.sv - request/serial-output bundle for serial_pattern_tx
interface serial_pattern_tx_if #(
  parameter int W  = 8,
  parameter int LW = 4,
  parameter int RW = 4,
  parameter int GW = 4
);
  logic          start;
  logic [W-1:0]  pattern;
  logic [LW-1:0] len;
  logic [RW-1:0] repeat_n;
  logic [GW-1:0] gap;
  logic          abort;
  logic          out;
  logic          out_valid;
  logic          busy;
  logic          done;

  modport master (
    output start, pattern, len, repeat_n, gap, abort,
    input  out, out_valid, busy, done
  );

  modport slave (
    input  start, pattern, len, repeat_n, gap, abort,
    output out, out_valid, busy, done
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - MSB-first serial pattern shifter with repeat and idle gap
module serial_pattern_tx #(
  parameter int   W        = 8,
  parameter int   LW       = 4,
  parameter int   RW       = 4,
  parameter int   GW       = 4,
  parameter logic IDLE_LVL = 1'b1
) (
  input logic               clk,
  input logic               rst,
  serial_pattern_tx_if.slave bus
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  pat_q, pat_d;
  logic [LW-1:0] len_q, len_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [GW-1:0] gap_cfg_q, gap_cfg_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [LW-1:0] len_clamped;

  // State, counters and registered outputs; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      rep_q       <= '0;
      gap_cfg_q   <= '0;
      gap_cnt_q   <= '0;
      idx_q       <= '0;
      out_q       <= IDLE_LVL;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      rep_q       <= rep_d;
      gap_cfg_q   <= gap_cfg_d;
      gap_cnt_q   <= gap_cnt_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Out-of-range lengths fall back to the full pattern width
  always_comb begin
    len_clamped = bus.len;
    if ((bus.len == '0) || (int'(bus.len) > W)) len_clamped = LW'(W);
  end

  // Next state: capture on start, walk bits down, count repetitions and gap cycles
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    rep_d     = rep_q;
    gap_cfg_d = gap_cfg_q;
    gap_cnt_d = gap_cnt_q;
    idx_d     = idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          pat_d     = bus.pattern;
          len_d     = len_clamped;
          rep_d     = (bus.repeat_n == '0) ? RW'(1) : bus.repeat_n;
          gap_cfg_d = bus.gap;
          gap_cnt_d = '0;
          idx_d     = IW'(len_clamped - LW'(1));
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (idx_q == '0) begin
          if (rep_q > RW'(1)) begin
            rep_d = rep_q - RW'(1);
            if (gap_cfg_q != '0) begin
              gap_cnt_d = gap_cfg_q;
              state_d   = GAP;
            end else begin
              idx_d = IW'(len_q - LW'(1));
            end
          end else begin
            rep_d   = '0;
            state_d = DONE;
          end
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      GAP: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (gap_cnt_q <= GW'(1)) begin
          gap_cnt_d = '0;
          idx_d     = IW'(len_q - LW'(1));
          state_d   = SHIFT;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered with the state
  always_comb begin
    out_d       = IDLE_LVL;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    unique case (state_d)
      SHIFT: begin
        out_d       = pat_d[idx_d];
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
      GAP:     busy_d = 1'b1;
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb/tb_serial_pattern_tx.sv - scoreboard bench for serial_pattern_tx
module tb_serial_pattern_tx;

  typedef struct {
    int cyc;
    bit b;
  } bit_exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;
  bit   mon_en;

  bit_exp_t exp_bits[$];
  int       exp_done[$];

  serial_pattern_tx_if #(.W(8), .LW(4), .RW(4), .GW(4)) bus ();

  serial_pattern_tx #(.W(8), .LW(4), .RW(4), .GW(4), .IDLE_LVL(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected bits: n bits of v, MSB first, starting at cycle c0
  task automatic push_bits(input int c0, input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      bit_exp_t e;
      e.cyc = c0 + i;
      e.b   = v[n-1-i];
      exp_bits.push_back(e);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic go(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                    input logic [3:0] g);
    bus.pattern  = p;
    bus.len      = l;
    bus.repeat_n = r;
    bus.gap      = g;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_out"}, bus.out, 1'b1);
    chk({name, "_valid"}, bus.out_valid, 1'b0);
    chk({name, "_busy"}, bus.busy, 1'b0);
    chk({name, "_done"}, bus.done, 1'b0);
  endtask

  // Monitor: consumes expected bits/done pulses whenever the DUT presents them
  always @(posedge clk) begin
    #1;
    cyc++;
    if (mon_en) begin
      if (bus.out_valid === 1'b1) begin
        if (exp_bits.size() == 0) begin
          chk("unexpected_bit", 32'(cyc), 32'hFFFFFFFF);
        end else begin
          bit_exp_t e;
          e = exp_bits.pop_front();
          chk("bit_cycle", 32'(cyc), 32'(e.cyc));
          chk("bit_value", 32'(bus.out), 32'(e.b));
          chk("bit_busy", 32'(bus.busy), 32'd1);
        end
      end else begin
        chk("idle_level", 32'(bus.out), 32'd1);
      end
      if (bus.done === 1'b1) begin
        if (exp_done.size() == 0) begin
          chk("unexpected_done", 32'(cyc), 32'hFFFFFFFF);
        end else begin
          chk("done_cycle", 32'(cyc), 32'(exp_done.pop_front()));
          chk("done_busy", 32'(bus.busy), 32'd0);
        end
      end
    end
  end

  initial begin
    int c;
    cyc = 0; errors = 0; checks = 0; mon_en = 1'b0;
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.pattern = '0;
    bus.len = '0; bus.repeat_n = '0; bus.gap = '0;
    repeat (3) tick();
    mon_en = 1'b1;
    chk_idle("reset");
    rst = 1'b0;
    tick();

    // 001, one repetition; inputs changed after capture must not matter
    c = cyc;
    push_bits(c + 1, 32'b001, 3);
    exp_done.push_back(c + 4);
    go(8'b001, 4'd3, 4'd1, 4'd0);
    bus.pattern = 8'hFF; bus.len = 4'd5; bus.repeat_n = 4'd7; bus.gap = 4'd9;
    chk("t1_busy", 32'(bus.busy), 32'd1);
    repeat (5) tick();

    // three back-to-back repetitions, no bubble
    c = cyc;
    push_bits(c + 1, 32'b001001001, 9);
    exp_done.push_back(c + 10);
    go(8'b001, 4'd3, 4'd3, 4'd0);
    repeat (11) tick();

    // two repetitions with 2-cycle gap
    c = cyc;
    push_bits(c + 1, 32'b001, 3);
    push_bits(c + 6, 32'b001, 3);
    exp_done.push_back(c + 9);
    go(8'b001, 4'd3, 4'd2, 4'd2);
    repeat (3) tick();
    chk("gap_busy", 32'(bus.busy), 32'd1);
    chk("gap_valid", 32'(bus.out_valid), 32'd0);
    repeat (7) tick();

    // len=0 means full width
    c = cyc;
    push_bits(c + 1, 32'b10100101, 8);
    exp_done.push_back(c + 9);
    go(8'hA5, 4'd0, 4'd1, 4'd0);
    repeat (10) tick();

    // repeat_n=0 means one repetition; gap unused
    c = cyc;
    push_bits(c + 1, 32'b110, 3);
    exp_done.push_back(c + 4);
    go(8'b110, 4'd3, 4'd0, 4'd3);
    repeat (6) tick();

    // len above W clamps to W; a second start mid-transmission is ignored
    c = cyc;
    push_bits(c + 1, 32'b10110011, 8);
    exp_done.push_back(c + 9);
    go(8'b10110011, 4'd12, 4'd1, 4'd0);
    tick();
    go(8'h00, 4'd2, 4'd4, 4'd0);
    repeat (9) tick();

    // abort during SHIFT, then start together with abort from IDLE
    c = cyc;
    push_bits(c + 1, 32'b10, 2);
    go(8'b101, 4'd3, 4'd2, 4'd0);
    tick();
    bus.abort = 1'b1;
    tick();
    chk_idle("abort");
    push_bits(c + 4, 32'b01, 2);
    exp_done.push_back(c + 6);
    go(8'b01, 4'd2, 4'd1, 4'd0);
    bus.abort = 1'b0;
    repeat (5) tick();

    // reset during GAP, then a clean restart
    c = cyc;
    push_bits(c + 1, 32'b001, 3);
    go(8'b001, 4'd3, 4'd2, 4'd3);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk_idle("rst_gap");
    rst = 1'b0;
    tick();
    push_bits(c + 7, 32'b10, 2);
    exp_done.push_back(c + 9);
    go(8'b10, 4'd2, 4'd1, 4'd0);
    repeat (5) tick();

    // maximum repeat and gap counts, 1-bit pattern of 0
    c = cyc;
    for (int k = 0; k < 15; k++) push_bits(c + 1 + 16 * k, 32'b0, 1);
    exp_done.push_back(c + 226);
    go(8'h00, 4'd1, 4'd15, 4'd15);
    repeat (230) tick();

    chk("bits_left", 32'(exp_bits.size()), 32'd0);
    chk("done_left", 32'(exp_done.size()), 32'd0);
    chk_idle("final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
